stonyman_readout: RTL

- Scan sequencer for the vision chip plus SPI front end for its pixel ADC; sits in TOPLEVEL between the chip/ADC pins (resp, resv, incp, incv, inphi, CS, SCLK, MISO) and the frame-buffer writer.
- Walks the pixel array row-major, converts each pixel with one 16-clock SPI ADC transaction, and emits each sample on a valid/ready stream tagged with row/column and start-of-frame/end-of-line.

---
 rtl/stonyman_readout.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/stonyman_readout.sv
// Stonyman scan sequencer with SPI ADC front end: walks the pixel array
// row-major, converts each pixel and streams samples tagged with row/col.
module stonyman_readout #(
  parameter int ROWS     = 112,
  parameter int COLS     = 112,
  parameter int SCLK_DIV = 2,
  parameter int PULSE_W  = 2,
  parameter int SETTLE   = 4,
  parameter int ADC_BITS = 12
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic                start,
  output logic                busy,
  output logic                frame_done,
  output logic                resp,
  output logic                resv,
  output logic                incp,
  output logic                incv,
  output logic                inphi,
  output logic                CS,
  output logic                SCLK,
  input  logic                MISO,
  output logic                px_valid,
  input  logic                px_ready,
  output logic [ADC_BITS-1:0] px_data,
  output logic [7:0]          px_row,
  output logic [7:0]          px_col,
  output logic                px_sof,
  output logic                px_eol
);

  typedef enum logic [3:0] {
    S_IDLE, S_RROW, S_RCOL, S_SETTLE, S_CONV, S_OUT, S_INCP, S_INCV, S_DONE
  } state_t;

  localparam logic [15:0] PW_LAST  = 16'(PULSE_W - 1);
  localparam logic [15:0] ST_LAST  = 16'(SETTLE - 1);
  localparam logic [15:0] DIV_LAST = 16'(SCLK_DIV - 1);
  localparam logic [5:0]  PH_LAST  = 6'd32;
  localparam logic [4:0]  BIT_LO   = 5'd4;
  localparam logic [4:0]  BIT_HI   = 5'(4 + ADC_BITS);
  localparam logic [7:0]  ROW_LAST = 8'(ROWS - 1);
  localparam logic [7:0]  COL_LAST = 8'(COLS - 1);

  state_t                state_reg, state_next;
  logic [15:0]           cnt_reg;
  logic [5:0]            phase_reg;
  logic [7:0]            row_reg, col_reg;
  logic [ADC_BITS-1:0]   data_reg;
  logic                  half_end, sclk_rise, capture, xfer;

  // A CONV transaction is 33 SCLK half-periods; phase counts them and SCLK
  // is low on odd phases, so an odd phase ending is a rising SCLK edge.
  assign half_end  = (cnt_reg == DIV_LAST);
  assign sclk_rise = (state_reg == S_CONV) && phase_reg[0] && half_end;
  assign capture   = sclk_rise && (phase_reg[5:1] >= BIT_LO) && (phase_reg[5:1] < BIT_HI);
  assign xfer      = (state_reg == S_OUT) && px_ready;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state_reg <= S_IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (start) state_next = S_RROW;
      S_RROW:   if (cnt_reg == PW_LAST) state_next = S_RCOL;
      S_RCOL:   if (cnt_reg == PW_LAST) state_next = S_SETTLE;
      S_SETTLE: if (cnt_reg == ST_LAST) state_next = S_CONV;
      S_CONV:   if (phase_reg == PH_LAST && half_end) state_next = S_OUT;
      S_OUT: begin
        if (px_ready) begin
          if (col_reg != COL_LAST)      state_next = S_INCP;
          else if (row_reg != ROW_LAST) state_next = S_INCV;
          else                          state_next = S_DONE;
        end
      end
      S_INCP:   if (cnt_reg == PW_LAST) state_next = S_SETTLE;
      S_INCV:   if (cnt_reg == PW_LAST) state_next = S_RCOL;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt_reg   <= '0;
      phase_reg <= '0;
      row_reg   <= '0;
      col_reg   <= '0;
      data_reg  <= '0;
    end else begin
      if (state_next != state_reg) begin
        cnt_reg   <= '0;
        phase_reg <= '0;
      end else if (state_reg == S_CONV && half_end) begin
        cnt_reg   <= '0;
        phase_reg <= phase_reg + 6'd1;
      end else begin
        cnt_reg <= cnt_reg + 16'd1;
      end

      if (capture) data_reg <= ADC_BITS'({data_reg, MISO});

      // Pointer moves only on an accepted transfer, mirroring the chip pulses.
      if (state_reg == S_IDLE && start) begin
        row_reg <= '0;
        col_reg <= '0;
      end else if (xfer) begin
        if (col_reg != COL_LAST) begin
          col_reg <= col_reg + 8'd1;
        end else if (row_reg != ROW_LAST) begin
          row_reg <= row_reg + 8'd1;
          col_reg <= '0;
        end
      end
    end
  end

  always_comb begin
    busy       = (state_reg != S_IDLE) && (state_reg != S_DONE);
    frame_done = (state_reg == S_DONE);
    resv       = (state_reg == S_RROW);
    resp       = (state_reg == S_RCOL);
    incp       = (state_reg == S_INCP);
    incv       = (state_reg == S_INCV);
    inphi      = 1'b0;
    CS         = (state_reg != S_CONV);
    SCLK       = (state_reg == S_CONV) ? ~phase_reg[0] : 1'b1;
    px_valid   = (state_reg == S_OUT);
    px_sof     = (state_reg == S_OUT) && (row_reg == 8'd0) && (col_reg == 8'd0);
    px_eol     = (state_reg == S_OUT) && (col_reg == COL_LAST);
    px_data    = data_reg;
    px_row     = row_reg;
    px_col     = col_reg;
  end

endmodule
